// File: rtl/rx_fifo_pkg.sv
// Shared types and entry layout for the store-and-forward RX frame FIFO.
package rx_fifo_pkg;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_ACCEPT,
        WR_DROP
    } wr_state_t;

    // Flag bits sit directly above the payload in each stored entry.
    localparam int unsigned FLAG_W   = 2;
    localparam int unsigned LAST_BIT = 1;
    localparam int unsigned ERR_BIT  = 0;

endpackage

// File: rtl/rx_fifo_ram.sv
// Simple dual-port frame storage: synchronous write, asynchronous read.
module rx_fifo_ram #(
    parameter int unsigned Width = 10,
    parameter int unsigned Depth = 2048,
    parameter int unsigned AddrW = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rx_frame_fifo.sv
// Store-and-forward RX frame FIFO; frames become readable only once fully committed.
// Define RX_FRAME_FIFO_DROP_BAD_EN to discard errored frames instead of forwarding them.
module rx_frame_fifo
    import rx_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 2048,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_last,
    input  logic              s_error,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              m_error,
    output logic              drop_ovf,
    output logic              drop_bad,
    output logic [ADDR_W:0]   level
);

    localparam int unsigned PTR_W   = ADDR_W + 1;
    localparam int unsigned ENTRY_W = DATA_W + FLAG_W;

    wr_state_t          state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   wr_commit_q, wr_commit_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic               drop_ovf_q, drop_ovf_d;
    logic               drop_bad_q, drop_bad_d;
    logic               m_valid_q, m_last_q, m_error_q;
    logic [DATA_W-1:0]  m_data_q;
    logic               full, bad_drop, we, load, err_bit;
    logic [ENTRY_W-1:0] wdata, rdata;

`ifdef RX_FRAME_FIFO_DROP_BAD_EN
    logic unused_err;
    assign bad_drop   = s_error;
    assign err_bit    = 1'b0;
    assign unused_err = rdata[DATA_W+ERR_BIT];
`else
    assign bad_drop   = 1'b0;
    assign err_bit    = rdata[DATA_W+ERR_BIT];
`endif

    // Counts uncommitted beats too, and uses the pre-update read pointer.
    assign full = (wr_ptr_q - rd_ptr_q) == PTR_W'(DEPTH);

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        drop_ovf_d  = 1'b0;
        drop_bad_d  = 1'b0;
        we          = 1'b0;
        wdata                    = '0;
        wdata[DATA_W-1:0]        = s_data;
        wdata[DATA_W+LAST_BIT]   = s_last;
        wdata[DATA_W+ERR_BIT]    = s_error & s_last;
        if (s_valid) begin
            if (state_q == WR_DROP) begin
                if (s_last) begin
                    drop_ovf_d = 1'b1;
                    state_d    = WR_IDLE;
                end
            end else if (full) begin
                wr_ptr_d   = wr_commit_q;
                drop_ovf_d = s_last;
                state_d    = s_last ? WR_IDLE : WR_DROP;
            end else begin
                we       = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                if (s_last) begin
                    state_d = WR_IDLE;
                    if (bad_drop) begin
                        wr_ptr_d   = wr_commit_q;
                        drop_bad_d = 1'b1;
                    end else begin
                        wr_commit_d = wr_ptr_q + PTR_W'(1);
                    end
                end else begin
                    state_d = WR_ACCEPT;
                end
            end
        end
    end

    assign load     = (!m_valid_q || m_ready) && (rd_ptr_q != wr_commit_q);
    assign rd_ptr_d = load ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WR_IDLE;
            wr_ptr_q    <= '0;
            wr_commit_q <= '0;
            rd_ptr_q    <= '0;
            drop_ovf_q  <= 1'b0;
            drop_bad_q  <= 1'b0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            m_error_q   <= 1'b0;
            m_data_q    <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_commit_q <= wr_commit_d;
            rd_ptr_q    <= rd_ptr_d;
            drop_ovf_q  <= drop_ovf_d;
            drop_bad_q  <= drop_bad_d;
            if (load) begin
                m_valid_q <= 1'b1;
                m_data_q  <= rdata[DATA_W-1:0];
                m_last_q  <= rdata[DATA_W+LAST_BIT];
                m_error_q <= err_bit;
            end else if (m_ready) begin
                m_valid_q <= 1'b0;
            end
        end
    end

    rx_fifo_ram #(
        .Width (ENTRY_W),
        .Depth (DEPTH),
        .AddrW (ADDR_W)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (we),
        .waddr_i (wr_ptr_q[ADDR_W-1:0]),
        .wdata_i (wdata),
        .raddr_i (rd_ptr_q[ADDR_W-1:0]),
        .rdata_o (rdata)
    );

    assign m_data   = m_data_q;
    assign m_valid  = m_valid_q;
    assign m_last   = m_last_q;
    assign m_error  = m_error_q;
    assign drop_ovf = drop_ovf_q;
    assign drop_bad = drop_bad_q;
    assign level    = wr_commit_q - rd_ptr_q;

endmodule

// File: tb/tb_rx_frame_fifo.sv
// Directed/randomized bench for rx_frame_fifo; expected beats come from a frame-level queue model.
module tb_rx_frame_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 128;
    localparam int ADDR_W = 7;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] s_data = '0;
    logic              s_valid = 1'b0, s_last = 1'b0, s_error = 1'b0;
    logic [DATA_W-1:0] m_data;
    logic              m_valid, m_last, m_error, drop_ovf, drop_bad;
    logic              m_ready = 1'b0;
    logic [ADDR_W:0]   level;

    rx_frame_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_last   (s_last),
        .s_error  (s_error),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_last   (m_last),
        .m_error  (m_error),
        .drop_ovf (drop_ovf),
        .drop_bad (drop_bad),
        .level    (level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic              last;
        logic              err;
    } beat_t;

    beat_t       exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          n_ovf = 0, n_bad = 0, n_out = 0;
    bit          toggle = 0;
    logic        stall_prev = 1'b0;
    logic [DATA_W-1:0] data_prev = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: every accepted beat must be the oldest beat the model still owes.
    always @(negedge clk) begin
        if (rst_n) begin
            if (drop_ovf) n_ovf++;
            if (drop_bad) n_bad++;
            if (stall_prev) begin
                check("stall_valid", 32'(m_valid), 32'd1);
                check("stall_data", 32'(m_data), 32'(data_prev));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_beat", 32'(m_valid), 32'd0);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("out_data", 32'(m_data), 32'(e.d));
                    check("out_last", 32'(m_last), 32'(e.last));
                    check("out_error", 32'(m_error), 32'(e.err));
                    n_out++;
                end
            end
            stall_prev = m_valid && !m_ready;
            data_prev  = m_data;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        if (toggle) m_ready = ~m_ready;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            cyc();
            s_valid = 1'b0;
            s_last  = 1'b0;
            s_error = 1'b0;
        end
    endtask

    task automatic beat(input logic [DATA_W-1:0] d, input logic last, input logic err);
        cyc();
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        s_error = err;
    endtask

    // Noise on s_error for non-last beats must be ignored by the design.
    task automatic send_frame(input int len, input bit keep, input bit err_last);
        for (int i = 0; i < len; i++) begin
            logic [DATA_W-1:0] d;
            logic              l, e;
            d = DATA_W'($urandom);
            l = (i == len - 1);
            e = l ? err_lastBit(err_last) : 1'($urandom);
            beat(d, l, e);
            if (keep) exp_q.push_back('{d, l, l & err_last});
        end
    endtask

    function automatic logic err_lastBit(input bit b);
        return logic'(b);
    endfunction

    task automatic drain(input string tag, input int budget);
        int n = 0;
        m_ready = 1'b1;
        while ((exp_q.size() != 0 || m_valid) && n < budget) begin
            idle(1);
            n++;
        end
        toggle = 0;
        idle(1);
        check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_level"}, 32'(level), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int ovf0, bad0, out0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_m_error", 32'(m_error), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_drop_ovf", 32'(drop_ovf), 32'd0);
        check("rst_drop_bad", 32'(drop_bad), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: 64-beat frame, first output two cycles after the last beat
        m_ready = 1'b1;
        out0 = n_out;
        send_frame(64, 1, 0);
        idle(1);
        check("t1_lat_n1", 32'(m_valid), 32'd0);
        idle(1);
        check("t1_lat_n2", 32'(m_valid), 32'd1);
        drain("t1", 200);
        check("t1_count", 32'(n_out - out0), 32'd64);

        // 2: three back-to-back single-beat frames
        out0 = n_out;
        send_frame(1, 1, 0);
        send_frame(1, 1, 0);
        send_frame(1, 1, 0);
        drain("t2", 50);
        check("t2_count", 32'(n_out - out0), 32'd3);

        // 3: 100-beat frame with toggling m_ready
        out0 = n_out;
        toggle = 1;
        send_frame(100, 1, 0);
        toggle = 1;
        while (exp_q.size() != 0 && n_out - out0 < 100 && $time < 900_000) idle(1);
        drain("t3", 400);
        check("t3_count", 32'(n_out - out0), 32'd100);

        // Maximum frame of DEPTH beats fits an empty buffer
        ovf0 = n_ovf;
        out0 = n_out;
        m_ready = 1'b0;
        send_frame(DEPTH, 1, 0);
        idle(3);
        check("max_level", 32'(level), 32'(DEPTH - 1));
        check("max_no_drop", 32'(n_ovf - ovf0), 32'd0);
        drain("max", 400);
        check("max_count", 32'(n_out - out0), 32'(DEPTH));

        // A DEPTH+1 frame always overflows
        ovf0 = n_ovf;
        m_ready = 1'b0;
        send_frame(DEPTH + 1, 0, 0);
        idle(3);
        check("big_drop", 32'(n_ovf - ovf0), 32'd1);
        check("big_level", 32'(level), 32'd0);
        check("big_valid", 32'(m_valid), 32'd0);

        // 4: second frame overflows while the consumer is stalled; one beat sits in the output reg
        ovf0 = n_ovf;
        out0 = n_out;
        send_frame(70, 1, 0);
        send_frame(70, 0, 0);
        idle(3);
        check("t4_drop", 32'(n_ovf - ovf0), 32'd1);
        check("t4_level", 32'(level), 32'd69);
        drain("t4", 300);
        check("t4_count", 32'(n_out - out0), 32'd70);

        // 5: errored frame
        bad0 = n_bad;
        out0 = n_out;
        m_ready = 1'b1;
`ifdef RX_FRAME_FIFO_DROP_BAD_EN
        send_frame(12, 0, 1);
        idle(4);
        check("t5_bad_pulse", 32'(n_bad - bad0), 32'd1);
        check("t5_level", 32'(level), 32'd0);
        check("t5_valid", 32'(m_valid), 32'd0);
        check("t5_count", 32'(n_out - out0), 32'd0);
`else
        send_frame(12, 1, 1);
        drain("t5", 100);
        check("t5_bad_pulse", 32'(n_bad - bad0), 32'd0);
        check("t5_count", 32'(n_out - out0), 32'd12);
`endif

        // 6: reset in the middle of a frame
        ovf0 = n_ovf;
        bad0 = n_bad;
        out0 = n_out;
        for (int i = 0; i < 5; i++) beat(DATA_W'($urandom), 1'b0, 1'b0);
        cyc();
        rst_n   = 1'b0;
        s_valid = 1'b0;
        #1;
        check("t6_rst_valid", 32'(m_valid), 32'd0);
        check("t6_rst_level", 32'(level), 32'd0);
        idle(2);
        rst_n = 1'b1;
        send_frame(8, 1, 0);
        drain("t6", 100);
        check("t6_count", 32'(n_out - out0), 32'd8);
        check("t6_no_ovf", 32'(n_ovf - ovf0), 32'd0);
        check("t6_no_bad", 32'(n_bad - bad0), 32'd0);

        // 7: 5*DEPTH+ beats in 7-beat frames, pointer wrap
        ovf0 = n_ovf;
        out0 = n_out;
        m_ready = 1'b1;
        for (int f = 0; f < (5 * DEPTH + 6) / 7; f++) send_frame(7, 1, 0);
        drain("t7", 300);
        check("t7_count", 32'(n_out - out0), 32'(7 * ((5 * DEPTH + 6) / 7)));
        check("t7_no_drop", 32'(n_ovf - ovf0), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
